// File: rtl/cpu_pkg.sv
// Shared CPU types and widths.
// Used by the write-back arbiter and its FIFO.
package cpu_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Secondary write-back FIFO, generic by DEPTH.
// Exposes per-entry addr/valid so the top can build pending.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_req_t                      din,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr,
  output logic [DEPTH-1:0]             entry_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        wptr              <= wptr + PW'(1);
        entry_valid[wptr] <= 1'b1;
      end
      // push and pop never share a slot: full blocks push, empty blocks pop
      if (do_pop) begin
        rptr              <= rptr + PW'(1);
        entry_valid[rptr] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline writes win, long-latency results queue.
// Optional same-cycle bypass of an idle FIFO via WB_BYPASS_EN.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           p_we,
  input  logic [REG_ADDR_W-1:0]          p_addr,
  input  logic [DATA_W-1:0]              p_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [REG_ADDR_W-1:0]          s_addr,
  input  logic [DATA_W-1:0]              s_data,
  output logic [REG_ADDR_W-1:0]          addr_d,
  output logic [DATA_W-1:0]              data_d,
  output logic                           we,
  output logic [(1<<REG_ADDR_W)-1:0]     pending
);
  logic    p_eff;
  logic    s_acc;
  logic    s_keep;
  logic    bypass;
  logic    push;
  logic    pop;
  logic    full;
  logic    empty;
  wb_req_t head;
  wb_req_t p_req;
  wb_req_t s_req;
  wb_req_t nxt;
  logic    nxt_we;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]                 entry_valid;

  assign p_req   = '{addr: p_addr, data: p_data};
  assign s_req   = '{addr: s_addr, data: s_data};
  assign p_eff   = p_we && (p_addr != '0);
  assign s_ready = !full;
  assign s_acc   = s_valid && s_ready;
  assign s_keep  = s_acc && (s_addr != '0);

`ifdef WB_BYPASS_EN
  assign bypass = s_keep && empty && !p_eff;
`else
  assign bypass = 1'b0;
`endif

  assign push = s_keep && !bypass;
  assign pop  = !p_eff && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .din         (s_req),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  always_comb begin
    nxt_we   = 1'b1;
    nxt.addr = addr_d;
    nxt.data = data_d;
    unique case (1'b1)
      p_eff:   nxt = p_req;
      pop:     nxt = head;
      bypass:  nxt = s_req;
      default: nxt_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we     <= 1'b0;
      addr_d <= '0;
      data_d <= '0;
    end else begin
      we     <= nxt_we;
      addr_d <= nxt.addr;
      data_d <= nxt.data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending[entry_addr[i]] = 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter.
// Honors WB_BYPASS_EN for the secondary-latency step.
module tb_wb_arbiter;
  logic        clk;
  logic        reset;
  logic        p_we;
  logic [3:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic [15:0] pending;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  wb_arbiter #(.DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .p_we    (p_we),
    .p_addr  (p_addr),
    .p_data  (p_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_addr  (s_addr),
    .s_data  (s_data),
    .addr_d  (addr_d),
    .data_d  (data_d),
    .we      (we),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic exp_push(input logic [3:0] a,
                          input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {28'd0, addr_d}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_addr", {28'd0, addr_d}, {28'd0, e.a});
        chk("sb_data", data_d, e.d);
      end
    end
  end

  initial begin
    reset = 1'b0;
    p_we = 1'b0; p_addr = '0; p_data = '0;
    s_valid = 1'b0; s_addr = '0; s_data = '0;
    cyc();
    cyc();
    chk("rst_we", we, 0);
    chk("rst_addr", addr_d, 0);
    chk("rst_data", data_d, 0);
    chk("rst_pend", pending, 0);
    reset = 1'b1;
    cyc();
    chk("rel_we", we, 0);
    chk("rel_ready", s_ready, 1);
    chk("rel_pend", pending, 0);

    // primary latency and r0 no-op
    p_we = 1'b1; p_addr = 4'd5; p_data = 32'hDEADBEEF;
    exp_push(4'd5, 32'hDEADBEEF);
    cyc();
    chk("p_we", we, 1);
    chk("p_addr", addr_d, 5);
    chk("p_data", data_d, 32'hDEADBEEF);
    p_addr = 4'd0; p_data = 32'h1111;
    cyc();
    chk("p_r0_we", we, 0);
    chk("p_r0_hold", addr_d, 5);
    p_we = 1'b0;

    // primary busy while filling the FIFO
    for (int i = 0; i < 4; i++) begin
      p_we = 1'b1; p_addr = 4'd9; p_data = 32'h900 + i;
      s_valid = 1'b1; s_addr = 4'(i + 1); s_data = 32'hA0 + i;
      chk("fill_ready", s_ready, 1);
      exp_push(4'd9, 32'h900 + i);
      cyc();
    end
    s_valid = 1'b0;
    chk("full_ready", s_ready, 0);
    chk("full_pend", pending, 32'h001E);
    p_data = 32'h904;
    exp_push(4'd9, 32'h904);
    cyc();
    chk("starve_pend", pending, 32'h001E);
    chk("starve_addr", addr_d, 9);
    p_we = 1'b0;
    for (int k = 1; k <= 4; k++) exp_push(4'(k), 32'hA0 + k - 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("drain_we", we, 1);
      chk("drain_addr", addr_d, k);
      chk("drain_pend", pending, 32'h1E & ~((32'd1 << (k + 1)) - 1));
    end
    cyc();
    chk("drain_idle", we, 0);

    // full FIFO, held producer, pop and push across pointer wrap
    for (int i = 0; i < 4; i++) begin
      p_we = 1'b1; p_addr = 4'd9; p_data = 32'h910 + i;
      s_valid = 1'b1; s_addr = 4'(10 + i); s_data = 32'hB0 + i;
      exp_push(4'd9, 32'h910 + i);
      cyc();
    end
    p_we = 1'b0;
    s_addr = 4'd14; s_data = 32'hB4;
    chk("wrap_ready0", s_ready, 0);
    chk("wrap_pend0", pending, 32'h3C00);
    for (int k = 10; k <= 14; k++) exp_push(4'(k), 32'hB0 + k - 10);
    cyc();
    chk("wrap_addr10", addr_d, 10);
    chk("wrap_ready1", s_ready, 1);
    chk("wrap_pend1", pending, 32'h3800);
    cyc();
    s_valid = 1'b0;
    chk("wrap_addr11", addr_d, 11);
    chk("wrap_pend2", pending, 32'h7000);
    for (int k = 12; k <= 14; k++) begin
      cyc();
      chk("wrap_we", we, 1);
      chk("wrap_addr", addr_d, k);
      chk("wrap_data", data_d, 32'hB0 + k - 10);
    end
    cyc();
    chk("wrap_idle", we, 0);
    chk("wrap_pend_end", pending, 0);

    // secondary to r0 is swallowed
    s_valid = 1'b1; s_addr = 4'd0; s_data = 32'hDEAD;
    chk("s0_ready", s_ready, 1);
    cyc();
    s_valid = 1'b0;
    chk("s0_pend", pending, 0);
    cyc();
    chk("s0_we", we, 0);
    cyc();
    chk("s0_we2", we, 0);

    // secondary latency on an idle arbiter
    s_valid = 1'b1; s_addr = 4'd7; s_data = 32'h12345678;
    exp_push(4'd7, 32'h12345678);
    cyc();
    s_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("byp_we", we, 1);
    chk("byp_addr", addr_d, 7);
    chk("byp_pend", pending, 0);
    cyc();
    chk("byp_idle", we, 0);
    chk("byp_pend2", pending, 0);
`else
    chk("lat_we1", we, 0);
    chk("lat_pend1", pending, 32'h0080);
    cyc();
    chk("lat_we2", we, 1);
    chk("lat_addr", addr_d, 7);
    chk("lat_data", data_d, 32'h12345678);
    chk("lat_pend2", pending, 0);
`endif

    // reset while three entries are queued
    for (int i = 0; i < 3; i++) begin
      p_we = 1'b1; p_addr = 4'd9; p_data = 32'h920 + i;
      s_valid = 1'b1; s_addr = 4'(1 + i); s_data = 32'hC0 + i;
      if (i < 2) exp_push(4'd9, 32'h920 + i);
      cyc();
    end
    chk("pre_rst_pend", pending, 32'h000E);
    p_we = 1'b0; s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", addr_d, 0);
    chk("mid_rst_data", data_d, 0);
    cyc();
    cyc();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_we", we, 0);
      chk("post_rst_pend", pending, 0);
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
